exe_sequencer: RTL
==================

Name: exe_sequencer

Overview:
Fetch/decode/write-back controller that drives the execution unit's operand, operation and register-write ports from a stream of 16-bit instruction words. It reads the program from an instruction memory with a request/valid handshake and decodes each word into operator, source registers, immediate select and immediate data. It waits for the unit's result, then issues the register-file write-back. It is the initiating side of the execution unit's interface and sits between program memory and the execution unit.

Parameters:
PC_W, 8, program counter width; the PC wraps modulo 2^PC_W.
START_PC, 0, PC loaded on every start command.
EXE_LAT, 1, number of cycles operands are held before i_exe_data is sampled (minimum 1).

Ports:
i_clk  in  1  clock, rising edge.
i_rsn  in  1  reset, asynchronous, active-low.
i_start  in  1  one-cycle start pulse; honoured only in IDLE or HALT.
o_ireq  out  1  instruction fetch request.
o_pc  out  PC_W  fetch address, valid while o_ireq=1.
i_ivalid  in  1  i_instr valid; ignored while o_ireq=0.
i_instr  in  16  instruction or immediate word.
o_oper  out  3  operation to the unit: 0 ADD, 1 SUB, 2 SHIFT, 3 AND, 4 ORR, 5 XOR, 6 XNOR.
o_reg0  out  4  operand A register index.
o_reg1  out  4  operand B register index.
o_imm  out  1  1 = operand B is taken from o_data.
o_data  out  10  signed immediate operand.
o_reg2  out  4  write-back register index; 0 = no write.
o_data2  out  10  signed write-back data.
i_exe_data  in  10  unit result.
i_exe_flag  in  4  unit flags.
o_flag  out  4  flags latched at the last ALU write-back.
o_busy  out  1  1 in any state other than IDLE or HALT.
o_halted  out  1  1 in HALT.

Behaviour:
- Instruction word fields: [15:13] op, [12] I, [11:8] rd, [7:4] rs0, [3:0] rs1.
- op 0..6: ALU operation. If I=1, a second word follows and its [9:0] is the immediate; [15:10] of that word are ignored.
- op 7 with rd!=0: MOVI. A second word follows; rd <= word[9:0]; no ALU operation is issued.
- op 7 with rd=0: HALT, single word.
- Reset, or i_rsn low at any time: state IDLE, PC=START_PC, and every output is 0. Any instruction in flight is abandoned and no write-back is issued.
- State IDLE: on i_start, PC <= START_PC and go to FETCH.
- State FETCH: o_ireq=1, o_pc=PC.
  - Wait any number of cycles for i_ivalid.
  - On i_ivalid: latch the word; PC <= PC+1 (wrapping).
  - Next state is FETCH_IMM if (op<7 and I=1) or MOVI, HALT if HALT, otherwise EXEC.
- State FETCH_IMM: o_ireq=1, o_pc=PC. On i_ivalid: latch imm=i_instr[9:0]; PC <= PC+1. Next state is WB for MOVI, otherwise EXEC.
- State EXEC: hold o_oper=op, o_reg0=rs0, o_reg1=(I ? 0 : rs1), o_imm=I, o_data=(I ? imm : 0) for EXE_LAT cycles.
  - On the last of those cycles, capture i_exe_data and i_exe_flag.
  - Next state is WB.
- State WB, exactly one cycle:
  - o_reg2=rd. o_data2 = the captured result for an ALU op, or imm for MOVI.
  - o_flag is updated with the captured flags for ALU ops only.
  - Next state is FETCH.
  - If rd=0 for an ALU op, WB is still entered with o_reg2=0 (flags-only instruction).
- o_reg2 is 0 in every state except WB. o_oper, o_reg0, o_reg1, o_imm and o_data are 0 outside EXEC.
- State HALT: o_halted=1, o_busy=0, PC frozen. i_start restarts from START_PC.
- i_start while busy is ignored.
- Throughput with zero-wait memory: 2+EXE_LAT cycles per single-word ALU instruction, 3+EXE_LAT per immediate ALU instruction, 3 per MOVI.
- PC at 2^PC_W-1 followed by a fetch: PC wraps to 0, with no error.
- All data is 10-bit two's complement and is passed through without extension or saturation.

Decomposition:
- Shared package: opcode constants ADD..XNOR and OP_SYS=7; instruction field positions; state encoding (IDLE, FETCH, FETCH_IMM, EXEC, WB, HALT); data width 10; register-index width 4.
- No sub-module. The decode is a small combinational function inside the block; the latency counter stays inline.

Test Plan:
- Reset while in EXEC with o_reg2 pending -> all outputs 0, state IDLE, no WB cycle; after release, i_start fetches from address 0.
- Program [0xE300, 0x0018, 0xE000], zero-wait memory -> WB cycle shows o_reg2=3, o_data2=24; then o_halted=1 with PC=3.
- Word 0x0512 (ADD r5,r1,r2); model returns 48, flags 0x2 -> EXEC shows o_oper=0, o_reg0=1, o_reg1=2, o_imm=0; WB shows o_reg2=5, o_data2=48; o_flag=0x2.
- Words 0x3440, 0x0005 (SUB r4,r4,#5); model returns -5 -> EXEC shows o_imm=1, o_data=5, o_reg1=0; WB shows o_reg2=4, o_data2=10'h3FB.
- EXE_LAT=3 with i_ivalid delayed 4 cycles -> o_pc stable and o_ireq high while waiting; operands held 3 cycles; result sampled only on the third cycle.
- PC_W=2 with a 4-word program without HALT -> o_pc sequence 0,1,2,3,0; i_start pulsed mid-run has no effect.

Source files
------------

// File: rtl/exe_sequencer_pkg.sv
// exe_sequencer_pkg
// Shared definitions for the execution-unit sequencer: opcode values,
// instruction word field positions, FSM state encoding, data and register
// index widths, and the small instruction decode helpers.
package exe_sequencer_pkg;

    localparam int DATA_W  = 10;
    localparam int REG_W   = 4;
    localparam int INSTR_W = 16;

    // Opcodes carried in instruction bits [15:13]
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SHIFT = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_ORR   = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_SYS   = 3'd7;  // MOVI when rd != 0, HALT when rd == 0

    // Instruction word field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int IMM_BIT = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS0_HI = 7;
    localparam int RS0_LO = 4;
    localparam int RS1_HI = 3;
    localparam int RS1_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic             imm_sel;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs0;
        logic [REG_W-1:0] rs1;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op      = w[OP_HI:OP_LO];
        d.imm_sel = w[IMM_BIT];
        d.rd      = w[RD_HI:RD_LO];
        d.rs0     = w[RS0_HI:RS0_LO];
        d.rs1     = w[RS1_HI:RS1_LO];
        return d;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_SHIFT, OP_AND,
            OP_ORR, OP_XOR, OP_XNOR: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_halt(input instr_t d);
        return (d.op == OP_SYS) && (d.rd == '0);
    endfunction

    function automatic logic is_movi(input instr_t d);
        return (d.op == OP_SYS) && (d.rd != '0);
    endfunction

    // True when a second (immediate) word follows this instruction word
    function automatic logic needs_imm(input instr_t d);
        return (is_alu_op(d.op) && d.imm_sel) || is_movi(d);
    endfunction

endpackage

// File: rtl/exe_sequencer.sv
// exe_sequencer
// Fetch/decode/write-back controller for the execution unit. Fetches 16-bit
// words from instruction memory (request/valid), decodes them, drives the
// unit's operand/operation ports for EXE_LAT cycles, samples the result on
// the last of those cycles and issues a one-cycle register write-back.
// All outputs are registered.
//
// Ports:
//   i_clk, i_rsn          clock (rising edge), asynchronous active-low reset
//   i_start               start pulse, honoured only in IDLE or HALT
//   o_ireq, o_pc          fetch request and address
//   i_ivalid, i_instr     fetch response
//   o_oper, o_reg0, o_reg1, o_imm, o_data   operation/operands (EXEC only)
//   o_reg2, o_data2       write-back index/data (WB only, index 0 = no write)
//   i_exe_data, i_exe_flag  unit result and flags
//   o_flag                flags latched at the last ALU write-back
//   o_busy, o_halted      status
module exe_sequencer
    import exe_sequencer_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter int              EXE_LAT  = 1
) (
    input  logic               i_clk,
    input  logic               i_rsn,
    input  logic               i_start,
    output logic               o_ireq,
    output logic [PC_W-1:0]    o_pc,
    input  logic               i_ivalid,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [2:0]         o_oper,
    output logic [REG_W-1:0]   o_reg0,
    output logic [REG_W-1:0]   o_reg1,
    output logic               o_imm,
    output logic [DATA_W-1:0]  o_data,
    output logic [REG_W-1:0]   o_reg2,
    output logic [DATA_W-1:0]  o_data2,
    input  logic [DATA_W-1:0]  i_exe_data,
    input  logic [3:0]         i_exe_flag,
    output logic [3:0]         o_flag,
    output logic               o_busy,
    output logic               o_halted
);

    localparam int CNT_W = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(EXE_LAT - 1);

    state_t            state_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [2:0]        op_reg;
    logic [REG_W-1:0]  rd_reg;
    logic [REG_W-1:0]  rs0_reg;
    logic              movi_reg;
    logic [CNT_W-1:0]  lat_cnt_reg;

    instr_t            dec_w;
    logic [PC_W-1:0]   pc_inc;

    assign dec_w  = decode(i_instr);
    assign pc_inc = pc_reg + PC_W'(1);  // wraps modulo 2^PC_W

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= START_PC;
            op_reg      <= '0;
            rd_reg      <= '0;
            rs0_reg     <= '0;
            movi_reg    <= 1'b0;
            lat_cnt_reg <= '0;
            o_ireq      <= 1'b0;
            o_pc        <= '0;
            o_oper      <= '0;
            o_reg0      <= '0;
            o_reg1      <= '0;
            o_imm       <= 1'b0;
            o_data      <= '0;
            o_reg2      <= '0;
            o_data2     <= '0;
            o_flag      <= '0;
            o_busy      <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (i_start) begin
                        pc_reg    <= START_PC;
                        o_pc      <= START_PC;
                        o_ireq    <= 1'b1;
                        o_busy    <= 1'b1;
                        o_halted  <= 1'b0;
                        state_reg <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (i_ivalid) begin
                        op_reg   <= dec_w.op;
                        rd_reg   <= dec_w.rd;
                        rs0_reg  <= dec_w.rs0;
                        movi_reg <= is_movi(dec_w);
                        pc_reg   <= pc_inc;
                        o_pc     <= pc_inc;
                        if (is_halt(dec_w)) begin
                            o_ireq    <= 1'b0;
                            o_busy    <= 1'b0;
                            o_halted  <= 1'b1;
                            state_reg <= ST_HALT;
                        end else if (needs_imm(dec_w)) begin
                            // request stays high for the immediate word
                            state_reg <= ST_FETCH_IMM;
                        end else begin
                            // single-word ALU op: register operand B
                            o_ireq      <= 1'b0;
                            o_oper      <= dec_w.op;
                            o_reg0      <= dec_w.rs0;
                            o_reg1      <= dec_w.rs1;
                            o_imm       <= 1'b0;
                            o_data      <= '0;
                            lat_cnt_reg <= '0;
                            state_reg   <= ST_EXEC;
                        end
                    end
                end

                ST_FETCH_IMM: begin
                    if (i_ivalid) begin
                        pc_reg <= pc_inc;
                        o_pc   <= pc_inc;
                        o_ireq <= 1'b0;
                        if (movi_reg) begin
                            o_reg2    <= rd_reg;
                            o_data2   <= i_instr[DATA_W-1:0];
                            state_reg <= ST_WB;
                        end else begin
                            o_oper      <= op_reg;
                            o_reg0      <= rs0_reg;
                            o_reg1      <= '0;
                            o_imm       <= 1'b1;
                            o_data      <= i_instr[DATA_W-1:0];
                            lat_cnt_reg <= '0;
                            state_reg   <= ST_EXEC;
                        end
                    end
                end

                ST_EXEC: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        // last operand cycle: result is captured straight
                        // into the write-back registers
                        o_oper    <= '0;
                        o_reg0    <= '0;
                        o_reg1    <= '0;
                        o_imm     <= 1'b0;
                        o_data    <= '0;
                        o_reg2    <= rd_reg;
                        o_data2   <= i_exe_data;
                        o_flag    <= i_exe_flag;
                        state_reg <= ST_WB;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
                    end
                end

                ST_WB: begin
                    o_reg2    <= '0;
                    o_data2   <= '0;
                    o_ireq    <= 1'b1;
                    state_reg <= ST_FETCH;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
